// File: rtl/issue_arbiter.sv
// Issue-stage arbiter: grants int/mem/mult/div queues so that their results never
// collide on the single CDB, using a forward-looking reservation vector and a divider busy counter.
module issue_arbiter #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ready_int,
    input  logic               ready_mem,
    input  logic               ready_mult,
    input  logic               ready_div,
    output logic               issue_int,
    output logic               issue_mem,
    output logic               issue_mult,
    output logic               issue_div,
    output logic [DIV_LAT-2:0] cdb_resv,
    output logic               div_busy
);

    localparam int RW = DIV_LAT - 1;
    localparam int CW = $clog2(DIV_LAT);

    logic [RW-1:0] resv, resv_next;
    logic [CW-1:0] div_cnt, div_cnt_next;
    logic          rr_mem, rr_mem_next;
    logic          slot_free;

    always_comb begin
        slot_free = ~resv[0];
        // Grants are gated by rst so nothing leaves the block while reset is held.
        issue_int  = rst & slot_free & ready_int & (~ready_mem | ~rr_mem);
        issue_mem  = rst & slot_free & ready_mem & (~ready_int |  rr_mem);
        issue_mult = rst & ready_mult & ~resv[MULT_LAT-1];
        issue_div  = rst & ready_div  & (div_cnt == '0);

        resv_next = {1'b0, resv[RW-1:1]};
        resv_next[MULT_LAT-2] = resv_next[MULT_LAT-2] | issue_mult;
        resv_next[DIV_LAT-2]  = resv_next[DIV_LAT-2]  | issue_div;

        div_cnt_next = div_cnt;
        if (issue_div)
            div_cnt_next = CW'(DIV_LAT - 1);
        else if (div_cnt != '0)
            div_cnt_next = div_cnt - 1'b1;

        rr_mem_next = rr_mem;
        if (issue_int)
            rr_mem_next = 1'b1;
        else if (issue_mem)
            rr_mem_next = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resv    <= '0;
            div_cnt <= '0;
            rr_mem  <= 1'b0;
        end else begin
            resv    <= resv_next;
            div_cnt <= div_cnt_next;
            rr_mem  <= rr_mem_next;
        end
    end

    assign cdb_resv = resv;
    assign div_busy = (div_cnt != '0);

endmodule
